// File: rtl/nearest_neighbor_upscale.sv
// nearest_neighbor_upscale
//   Streaming nearest-neighbour upscaler. One input line is captured into a
//   line buffer (S_FILL), then every output line that maps onto that source
//   row is emitted from the buffer (S_EMIT). Filling and emitting never
//   overlap, so the single line buffer can be overwritten safely.
//
//   Ports
//     clk, rst_n              clock, asynchronous active-low reset
//     in_pixel_data/_valid    input pixel stream, raster order
//     in_pixel_data_ready     registered; high only while filling
//     out_pixel_data/_valid   output pixel stream, data is 0 while idle
//     out_pixel_data_ready    downstream accept
//     out_sof, out_eol        first pixel of frame / last pixel of line
//
//   Handshake: a transfer happens on a rising clk edge where valid and ready
//   are both high. A producer holding valid keeps its data stable until that
//   edge; valid never depends combinationally on ready.
module nearest_neighbor_upscale #(
  parameter int PIXEL_DATA_WIDTH = 8,
  parameter int IN_FRAME_WIDTH   = 4,
  parameter int IN_FRAME_HEIGHT  = 4,
  parameter int OUT_FRAME_WIDTH  = 8,
  parameter int OUT_FRAME_HEIGHT = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PIXEL_DATA_WIDTH-1:0] in_pixel_data,
  input  logic                        in_pixel_data_valid,
  output logic                        in_pixel_data_ready,
  output logic [PIXEL_DATA_WIDTH-1:0] out_pixel_data,
  output logic                        out_pixel_data_valid,
  input  logic                        out_pixel_data_ready,
  output logic                        out_sof,
  output logic                        out_eol
);

  // 16.16 source step per output pixel / line (floor).
  localparam logic [31:0] X_RATIO = 32'((IN_FRAME_WIDTH << 16) / OUT_FRAME_WIDTH);
  localparam logic [31:0] Y_RATIO = 32'((IN_FRAME_HEIGHT << 16) / OUT_FRAME_HEIGHT);
  localparam int          AW      = (IN_FRAME_WIDTH > 1) ? $clog2(IN_FRAME_WIDTH) : 1;

  localparam logic [10:0] IN_W_LAST  = 11'(IN_FRAME_WIDTH - 1);
  localparam logic [10:0] OUT_W_LAST = 11'(OUT_FRAME_WIDTH - 1);
  localparam logic [10:0] OUT_H_LAST = 11'(OUT_FRAME_HEIGHT - 1);

  typedef enum logic {S_FILL, S_EMIT} state_t;

  state_t      state;
  logic [10:0] in_x, in_y, out_x, out_y, row;

  logic [PIXEL_DATA_WIDTH-1:0] line_buf [IN_FRAME_WIDTH];

  // Output coordinate -> source coordinate.
  function automatic logic [10:0] map_coord(input logic [10:0] c, input logic [31:0] ratio);
    return 11'((43'(c) * 43'(ratio)) >> 16);
  endfunction

  logic          in_xfer, out_xfer;
  logic          last_x, last_y, next_row_same;
  logic [10:0]   next_x, next_y, load_x, src_x;
  logic [AW-1:0] rd_addr;
  logic [PIXEL_DATA_WIDTH-1:0] rd_data;

  assign in_xfer       = in_pixel_data_valid & in_pixel_data_ready;
  assign out_xfer      = out_pixel_data_valid & out_pixel_data_ready;
  assign last_x        = (out_x == OUT_W_LAST);
  assign last_y        = (out_y == OUT_H_LAST);
  assign next_x        = last_x ? 11'd0 : out_x + 11'd1;
  assign next_y        = out_y + 11'd1;
  assign next_row_same = (map_coord(next_y, Y_RATIO) == row);

  // out_x/out_y name the pixel in the output register (or the next one to
  // load while idle). The buffer read is registered straight into the output
  // register, so loading is enabled only when the register is empty or is
  // being drained this cycle; a stall simply holds everything in place.
  assign load_x  = out_xfer ? next_x : out_x;
  assign src_x   = map_coord(load_x, X_RATIO);
  assign rd_addr = src_x[AW-1:0];
  assign rd_data = line_buf[rd_addr];

  always_ff @(posedge clk) begin
    if (in_xfer) line_buf[in_x[AW-1:0]] <= in_pixel_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= S_FILL;
      in_x                 <= '0;
      in_y                 <= '0;
      out_x                <= '0;
      out_y                <= '0;
      row                  <= '0;
      in_pixel_data_ready  <= 1'b0;
      out_pixel_data       <= '0;
      out_pixel_data_valid <= 1'b0;
      out_sof              <= 1'b0;
      out_eol              <= 1'b0;
    end else begin
      case (state)
        S_FILL: begin
          in_pixel_data_ready <= 1'b1;
          if (in_xfer) begin
            if (in_x == IN_W_LAST) begin
              in_x                <= '0;
              row                 <= in_y;
              state               <= S_EMIT;
              in_pixel_data_ready <= 1'b0;
            end else begin
              in_x <= in_x + 11'd1;
            end
          end
        end

        S_EMIT: begin
          in_pixel_data_ready <= 1'b0;
          if (!out_pixel_data_valid) begin
            // First pixel of the burst for this row.
            out_pixel_data_valid <= 1'b1;
            out_pixel_data       <= rd_data;
            out_sof              <= (out_x == 11'd0) && (out_y == 11'd0);
            out_eol              <= last_x;
          end else if (out_pixel_data_ready) begin
            if (last_x) begin
              out_x <= '0;
              if (last_y || !next_row_same) begin
                // Row finished: back to filling the next (or first) row.
                out_y                <= last_y ? 11'd0 : next_y;
                in_y                 <= last_y ? 11'd0 : in_y + 11'd1;
                state                <= S_FILL;
                in_pixel_data_ready  <= 1'b1;
                out_pixel_data_valid <= 1'b0;
                out_pixel_data       <= '0;
                out_sof              <= 1'b0;
                out_eol              <= 1'b0;
              end else begin
                // Replicated line from the same buffered row, no bubble.
                out_y          <= next_y;
                out_pixel_data <= rd_data;
                out_sof        <= 1'b0;
                out_eol        <= (OUT_W_LAST == 11'd0);
              end
            end else begin
              out_x          <= next_x;
              out_pixel_data <= rd_data;
              out_sof        <= 1'b0;
              out_eol        <= (next_x == OUT_W_LAST);
            end
          end
        end

        default: state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_nearest_neighbor_upscale.sv
module tb_nearest_neighbor_upscale;
  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         out_ready;
  int           sel;

  logic [W-1:0] od [3];
  logic         ov [3];
  logic         os [3];
  logic         oe [3];
  logic         ir [3];

  // 0: 4x4->8x8, 1: 3x3->4x4, 2: 4x4->4x4
  nearest_neighbor_upscale #(.PIXEL_DATA_WIDTH(W), .IN_FRAME_WIDTH(4), .IN_FRAME_HEIGHT(4),
    .OUT_FRAME_WIDTH(8), .OUT_FRAME_HEIGHT(8)) u_up8 (
    .clk(clk), .rst_n(rst_n), .in_pixel_data(in_data), .in_pixel_data_valid(in_valid && sel == 0),
    .in_pixel_data_ready(ir[0]), .out_pixel_data(od[0]), .out_pixel_data_valid(ov[0]),
    .out_pixel_data_ready(out_ready), .out_sof(os[0]), .out_eol(oe[0]));

  nearest_neighbor_upscale #(.PIXEL_DATA_WIDTH(W), .IN_FRAME_WIDTH(3), .IN_FRAME_HEIGHT(3),
    .OUT_FRAME_WIDTH(4), .OUT_FRAME_HEIGHT(4)) u_up34 (
    .clk(clk), .rst_n(rst_n), .in_pixel_data(in_data), .in_pixel_data_valid(in_valid && sel == 1),
    .in_pixel_data_ready(ir[1]), .out_pixel_data(od[1]), .out_pixel_data_valid(ov[1]),
    .out_pixel_data_ready(out_ready), .out_sof(os[1]), .out_eol(oe[1]));

  nearest_neighbor_upscale #(.PIXEL_DATA_WIDTH(W), .IN_FRAME_WIDTH(4), .IN_FRAME_HEIGHT(4),
    .OUT_FRAME_WIDTH(4), .OUT_FRAME_HEIGHT(4)) u_id (
    .clk(clk), .rst_n(rst_n), .in_pixel_data(in_data), .in_pixel_data_valid(in_valid && sel == 2),
    .in_pixel_data_ready(ir[2]), .out_pixel_data(od[2]), .out_pixel_data_valid(ov[2]),
    .out_pixel_data_ready(out_ready), .out_sof(os[2]), .out_eol(oe[2]));

  logic [W-1:0] cur_od;
  logic         cur_ov, cur_os, cur_oe, cur_ir;
  always_comb begin
    cur_od = od[sel];
    cur_ov = ov[sel];
    cur_os = os[sel];
    cur_oe = oe[sel];
    cur_ir = ir[sel];
  end

  // ---------------- bookkeeping ----------------
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int iw, ih, ow, oh;
  logic [W-1:0] img[$];
  logic [9:0]   exp_q[$];   // {sof, eol, data}
  int           blen_q[$];  // expected burst lengths with ready held high
  logic [9:0]   cap_q[$];
  logic [9:0]   cap_s1[$];
  logic [9:0]   cap_s2[$];

  function automatic int map_c(input int c, input int n_in, input int n_out);
    return (c * ((n_in << 16) / n_out)) >> 16;
  endfunction

  task automatic make_img(input bit rnd);
    img.delete();
    for (int y = 0; y < ih; y++)
      for (int x = 0; x < iw; x++)
        img.push_back(rnd ? W'($urandom_range(0, 255)) : W'(y * 16 + x));
  endtask

  task automatic model_frame();
    for (int oy = 0; oy < oh; oy++)
      for (int ox = 0; ox < ow; ox++) begin
        logic [W-1:0] d;
        logic s, e;
        d = img[map_c(oy, ih, oh) * iw + map_c(ox, iw, ow)];
        s = (ox == 0 && oy == 0);
        e = (ox == ow - 1);
        exp_q.push_back({s, e, d});
      end
    for (int r = 0; r < ih; r++) begin
      int k = 0;
      for (int oy = 0; oy < oh; oy++) if (map_c(oy, ih, oh) == r) k++;
      blen_q.push_back(k * ow);
    end
  endtask

  // ---------------- output ready driver ----------------
  bit rand_ready = 1'b0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit         mon_en = 1'b0;
  bit         burst_chk = 1'b0;
  int         cyc = 0;
  int         last_in_cyc = 0;
  int         run_len = 0;
  logic       prev_ov = 1'b0;
  logic       prev_rdy = 1'b0;
  logic [9:0] held = '0;

  always @(negedge clk) begin
    cyc++;
    if (mon_en && rst_n) begin
      if (in_valid && cur_ir) last_in_cyc = cyc;
      check("in_ready_during_emit", 32'(cur_ir && cur_ov), 0);
      if (!cur_ov) check("idle_data_zero", 32'(cur_od), 0);
      if (cur_ov && !prev_ov) check("valid_latency", 32'(cyc - last_in_cyc), 2);
      if (cur_ov && prev_ov && !prev_rdy) check("stall_hold", {cur_os, cur_oe, cur_od}, held);
      if (cur_ov) run_len++;
      if (!cur_ov && prev_ov && burst_chk)
        check("burst_len", 32'(run_len), (blen_q.size() > 0) ? 32'(blen_q.pop_front()) : 32'hffff_ffff);
      if (!cur_ov) run_len = 0;
      if (cur_ov && out_ready) begin
        cap_q.push_back({cur_os, cur_oe, cur_od});
        check("out_pixel", {cur_os, cur_oe, cur_od},
              (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hffff_ffff);
      end
    end
    prev_ov  = cur_ov;
    prev_rdy = out_ready;
    held     = {cur_os, cur_oe, cur_od};
  end

  // ---------------- input driver ----------------
  task automatic send_pixels(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      int  t = 0;
      bit  ok = 1'b0;
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      in_data  = img[i % img.size()];
      in_valid = 1'b1;
      while (!ok && t < 1000) begin
        @(negedge clk);
        if (cur_ir) ok = 1'b1;
        @(posedge clk);
        #1;
        t++;
      end
      if (!ok) begin
        check("in_accept_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || cur_ov) && t < 4000) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check("drain_remaining", 32'(exp_q.size()), 0);
  endtask

  task automatic run_scenario(input int s, input int a, input int b, input int c, input int d,
                              input int frames, input bit rnd_pix, input bit gaps,
                              input bit rready, input bit bchk);
    @(posedge clk); #1;
    sel = s; iw = a; ih = b; ow = c; oh = d;
    rand_ready = rready;
    burst_chk  = bchk;
    exp_q.delete(); blen_q.delete(); cap_q.delete();
    make_img(rnd_pix);
    repeat (frames) model_frame();
    @(posedge clk); #1;
    mon_en = 1'b1;
    send_pixels(iw * ih * frames, gaps);
    wait_drain();
    mon_en = 1'b0;
    if (bchk) check("burst_count", 32'(blen_q.size()), 0);
    rand_ready = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 32'(cur_ov), 0);
    check({tag, "_data"},  32'(cur_od), 0);
    check({tag, "_sof"},   32'(cur_os), 0);
    check({tag, "_eol"},   32'(cur_oe), 0);
    check({tag, "_in_ready"}, 32'(cur_ir), 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_before_edge", 32'(cur_ir), 0);
    @(posedge clk); #1;
    check("in_ready_after_edge", 32'(cur_ir), 1);
  endtask

  // ---------------- spot-check table ----------------
  typedef struct {
    int         scen;
    int         idx;
    logic [9:0] exp;  // {sof, eol, data}
  } vec_t;
  vec_t vecs[14];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1, 0,  10'h200};
    vecs[1]  = '{1, 7,  10'h103};
    vecs[2]  = '{1, 8,  10'h000};
    vecs[3]  = '{1, 15, 10'h103};
    vecs[4]  = '{1, 18, 10'h011};
    vecs[5]  = '{1, 36, 10'h022};
    vecs[6]  = '{1, 63, 10'h133};
    vecs[7]  = '{2, 0,  10'h200};
    vecs[8]  = '{2, 3,  10'h102};
    vecs[9]  = '{2, 5,  10'h000};
    vecs[10] = '{2, 6,  10'h001};
    vecs[11] = '{2, 10, 10'h011};
    vecs[12] = '{2, 12, 10'h020};
    vecs[13] = '{2, 15, 10'h122};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; sel = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    release_reset();

    // 1: 4x4 -> 8x8, ready held high
    run_scenario(0, 4, 4, 8, 8, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    cap_s1 = cap_q;
    // 2: 3x3 -> 4x4
    run_scenario(1, 3, 3, 4, 4, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    cap_s2 = cap_q;
    // 3: 4x4 -> 8x8 with random backpressure and input gaps
    run_scenario(0, 4, 4, 8, 8, 1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("s3_count", 32'(cap_q.size()), 64);
    // 4: identity
    run_scenario(2, 4, 4, 4, 4, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("s4_count", 32'(cap_q.size()), 16);

    // 5: reset during the second output line of input row 1
    @(posedge clk); #1;
    sel = 0; iw = 4; ih = 4; ow = 8; oh = 8;
    exp_q.delete(); blen_q.delete(); cap_q.delete();
    make_img(1'b0);
    model_frame();
    mon_en = 1'b1;
    send_pixels(8, 1'b0);
    begin
      int t = 0;
      while (cap_q.size() < 27 && t < 500) begin @(negedge clk); t++; end
    end
    mon_en = 1'b0;
    check("pre_reset_valid", 32'(cur_ov), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("midreset");
    repeat (2) @(posedge clk);
    release_reset();
    run_scenario(0, 4, 4, 8, 8, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("post_reset_first", (cap_q.size() > 0) ? 32'(cap_q[0]) : 32'hffff_ffff, 32'h200);

    // 6: two back-to-back frames
    run_scenario(0, 4, 4, 8, 8, 2, 1'b0, 1'b0, 1'b0, 1'b1);
    check("b2b_count", 32'(cap_q.size()), 128);
    check("b2b_frame2_first", (cap_q.size() > 64) ? 32'(cap_q[64]) : 32'hffff_ffff, 32'h200);

    // 7: random pixels, gaps and backpressure over several 3x3 -> 4x4 frames
    run_scenario(1, 3, 3, 4, 4, 3, 1'b1, 1'b1, 1'b1, 1'b0);
    check("s7_count", 32'(cap_q.size()), 48);

    for (int i = 0; i < 14; i++) begin
      logic [31:0] act;
      if (vecs[i].scen == 1)
        act = (vecs[i].idx < cap_s1.size()) ? 32'(cap_s1[vecs[i].idx]) : 32'hffff_ffff;
      else
        act = (vecs[i].idx < cap_s2.size()) ? 32'(cap_s2[vecs[i].idx]) : 32'hffff_ffff;
      check($sformatf("table_s%0d_idx%0d", vecs[i].scen, vecs[i].idx), act, 32'(vecs[i].exp));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nearest_neighbor_upscale.md
Name: nearest_neighbor_upscale

Overview:
- Streaming nearest-neighbor upscaler. It is the counterpart of the downscale stage in the vision pipeline.
- It takes a raster frame of IN_FRAME_WIDTH x IN_FRAME_HEIGHT pixels at 1 pixel/clock and emits OUT_FRAME_WIDTH x OUT_FRAME_HEIGHT pixels by replicating source pixels and lines.
- Output rate exceeds input rate, so both sides use valid/ready handshakes and one input line is buffered.
- Used between inference-resolution buffers and display/overlay paths.

Parameters:
- PIXEL_DATA_WIDTH, 8, bits per pixel.
- IN_FRAME_WIDTH, 4, input pixels per line (1..2047).
- IN_FRAME_HEIGHT, 4, input lines per frame (1..2047).
- OUT_FRAME_WIDTH, 8, output pixels per line. Must be >= IN_FRAME_WIDTH and <= 2047.
- OUT_FRAME_HEIGHT, 8, output lines per frame. Must be >= IN_FRAME_HEIGHT and <= 2047.

Ports:
- clk  input  1  sole clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_pixel_data  input  PIXEL_DATA_WIDTH  input pixel, raster order.
- in_pixel_data_valid  input  1  input pixel valid. Upstream holds data stable until accepted.
- in_pixel_data_ready  output  1  block can accept an input pixel.
- out_pixel_data  output  PIXEL_DATA_WIDTH  output pixel.
- out_pixel_data_valid  output  1  output pixel valid.
- out_pixel_data_ready  input  1  downstream accepts the output pixel.
- out_sof  output  1  qualifies out_pixel_data_valid: first pixel of an output frame.
- out_eol  output  1  qualifies out_pixel_data_valid: last pixel of an output line.

Behaviour:
- One clock domain; reset is asynchronous and active-low.
- Handshakes:
  - An input transfer occurs when in_pixel_data_valid & in_pixel_data_ready.
  - An output transfer occurs when out_pixel_data_valid & out_pixel_data_ready.
- Ratios are 16.16 localparams: X_RATIO = (IN_FRAME_WIDTH<<16)/OUT_FRAME_WIDTH, Y_RATIO = (IN_FRAME_HEIGHT<<16)/OUT_FRAME_HEIGHT. Both are floor, with no +1.
- Source mapping:
  - src_x = (out_x*X_RATIO)>>16 and src_y = (out_y*Y_RATIO)>>16.
  - src_x <= IN_FRAME_WIDTH-1 is guaranteed by construction.
  - Equal sizes give the identity mapping.
- Counters are 11 bits: in_x, in_y, out_x, out_y. The line buffer is single-port-write/single-read, IN_FRAME_WIDTH x PIXEL_DATA_WIDTH, with 1-cycle registered read.
- State S_FILL:
  - in_pixel_data_ready=1. Each input transfer writes buf[in_x] and increments in_x.
  - On the transfer with in_x==IN_FRAME_WIDTH-1: in_x<=0, latch row=in_y, then go to S_EMIT.
  - in_pixel_data_ready drops the cycle after that transfer.
- State S_EMIT:
  - in_pixel_data_ready=0.
  - Emits output lines out_y for which src_y(out_y)==row. Each line is out_x=0..OUT_FRAME_WIDTH-1 with out_pixel_data=buf[src_x(out_x)].
  - At the end of each output line (transfer with out_eol), out_x<=0 and out_y increments.
  - If out_y was OUT_FRAME_HEIGHT-1: out_y<=0, in_y<=0, go to S_FILL.
  - Else if src_y(out_y+1)!=row: in_y<=in_y+1, go to S_FILL.
  - Else stay in S_EMIT for the replicated line.
- Latency and throughput:
  - out_pixel_data_valid first rises exactly 2 cycles after the last input transfer of a row.
  - With out_pixel_data_ready held high, out_pixel_data_valid stays high for K*OUT_FRAME_WIDTH consecutive cycles, with no bubbles. K is the number of output lines mapped to that row, K>=1.
  - out_pixel_data_valid deasserts the cycle after the final transfer of the burst.
- Backpressure:
  - While out_pixel_data_valid & !out_pixel_data_ready: out_pixel_data, out_sof and out_eol are held stable, and out_x/out_y do not advance.
  - The implementation must prefetch or skid so that no pixel is lost or duplicated.
- Sideband values:
  - out_sof=1 only for out_x==0 & out_y==0.
  - out_eol=1 only for out_x==OUT_FRAME_WIDTH-1.
  - out_pixel_data is 0 whenever out_pixel_data_valid=0.
- Reset values: out_pixel_data=0, out_pixel_data_valid=0, out_sof=0, out_eol=0, in_pixel_data_ready=0, all counters 0, state S_FILL.
- In_pixel_data_ready is registered. It first asserts on the first clk edge after rst_n deasserts.
- Reset mid-operation (rst_n low at any time):
  - Outputs are cleared immediately and the partial frame is discarded.
  - The next accepted input pixel is treated as input (0,0).
- Frame wrap: after the last output line, the block resumes S_FILL with row 0. Back-to-back frames need no idle cycles beyond the FILL phase.
- Line buffer overwrite is safe because S_FILL never overlaps S_EMIT.

Test Plan:
- 4x4->8x8, input pixel = y*16+x, out_ready=1 → 64 outputs with out(y,x)=(y>>1)*16+(x>>1); out_sof on output 0 only; out_eol on every 8th; each input row yields a 16-cycle contiguous valid burst starting 2 cycles after its last input.
- 3x3->4x4 (ratio 49152) → src map 0,0,1,2 on both axes; input row 0 produces 2 output lines, rows 1 and 2 one each; out(3,3)=in(2,2).
- 4x4->8x8 with pseudo-random out_ready (50%) → output sequence identical to scenario 1; data/sof/eol stable across every stalled cycle; in_ready never high during S_EMIT.
- 4x4->4x4 identity → output stream equals input stream; 4-pixel bursts, each 2 cycles after its row's last input.
- rst_n pulsed low during the second output line of row 1 → out_valid=0 and in_ready=0 immediately; after release, a fresh frame produces first output = input(0,0) with out_sof=1.
- Two back-to-back 4x4->8x8 frames → second frame's first output carries out_sof=1 and value 0x00; counters wrap cleanly with 128 total outputs and no extra or missing pixels.
